// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-8 registered demultiplexer slice.
//   NUM_OUT     : number of demux outputs (Y1..Y8)
//   SEL_W       : width of the select word {S3,S2,S1}
//   demux_sel_t : select word type, unsigned 0..NUM_OUT-1
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;

    typedef logic [SEL_W-1:0] demux_sel_t;

endpackage : demux_pkg

// File: rtl/demux_1_8_behav_always_if.sv
// ---------------------------------------------------------------------------
// demux_1_8_behav_always_if
// Bundles the data, select and output signals of the 1-to-8 demultiplexer.
//   A        : data to be routed (WIDTH bits)
//   S3,S2,S1 : select bits, S3 is the MSB
//   Y1..Y8   : registered demux outputs, Yn is live for select value n-1
//   sel_q    : registered select word (only when DEMUX_SEL_OUT_EN is defined)
// Modports:
//   master : drives A and the select, observes the outputs
//   slave  : the demultiplexer itself
// Configuration macro: DEMUX_SEL_OUT_EN adds sel_q to the bundle.
// ---------------------------------------------------------------------------
interface demux_1_8_behav_always_if #(
    parameter int WIDTH = 1
);
    import demux_pkg::*;

    logic [WIDTH-1:0] A;
    logic             S3;
    logic             S2;
    logic             S1;
    logic [WIDTH-1:0] Y1;
    logic [WIDTH-1:0] Y2;
    logic [WIDTH-1:0] Y3;
    logic [WIDTH-1:0] Y4;
    logic [WIDTH-1:0] Y5;
    logic [WIDTH-1:0] Y6;
    logic [WIDTH-1:0] Y7;
    logic [WIDTH-1:0] Y8;

`ifdef DEMUX_SEL_OUT_EN
    demux_sel_t       sel_q;

    modport master (
        output A, S3, S2, S1,
        input  Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, sel_q
    );

    modport slave (
        input  A, S3, S2, S1,
        output Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, sel_q
    );
`else
    modport master (
        output A, S3, S2, S1,
        input  Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8
    );

    modport slave (
        input  A, S3, S2, S1,
        output Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8
    );
`endif

endinterface : demux_1_8_behav_always_if

// File: rtl/demux_1_8_decode.sv
// ---------------------------------------------------------------------------
// demux_1_8_decode
// Purely combinational select decoder: turns the 3-bit select word into an
// 8-bit one-hot vector, bit n set for select value n.
//   sel    in  SEL_W    select word {S3,S2,S1}
//   onehot out NUM_OUT  one-hot decode, all zero when sel is not a clean 0..7
// ---------------------------------------------------------------------------
module demux_1_8_decode
    import demux_pkg::*;
(
    input  demux_sel_t         sel,
    output logic [NUM_OUT-1:0] onehot
);

    // Every legal code is listed explicitly so that a select carrying X or Z
    // bits falls into the default branch and no output gets enabled.
    always_comb begin
        onehot = '0;
        case (sel)
            3'd0:    onehot = 8'b0000_0001;
            3'd1:    onehot = 8'b0000_0010;
            3'd2:    onehot = 8'b0000_0100;
            3'd3:    onehot = 8'b0000_1000;
            3'd4:    onehot = 8'b0001_0000;
            3'd5:    onehot = 8'b0010_0000;
            3'd6:    onehot = 8'b0100_0000;
            3'd7:    onehot = 8'b1000_0000;
            default: onehot = '0;
        endcase
    end

endmodule : demux_1_8_decode

// File: rtl/demux_1_8_behav_always.sv
// ---------------------------------------------------------------------------
// demux_1_8_behav_always
// 1-to-8 demultiplexer with registered outputs. Data A is steered to the
// output selected by {S3,S2,S1}; all other outputs are driven to zero. Every
// output is re-registered on each rising clock edge, so outputs are glitch
// free and appear exactly one cycle after the inputs were sampled.
//   clk    in  1      clock, all state updates on the rising edge
//   rst_n  in  1      asynchronous, active-low reset; clears all outputs
//   bus    slave      demux_1_8_behav_always_if (A, S3..S1, Y1..Y8, sel_q)
// Parameter WIDTH: bit width of A and of each Y output.
// Configuration macro: DEMUX_SEL_OUT_EN registers the select word onto
// bus.sel_q alongside the outputs so downstream logic knows which Y is live.
// ---------------------------------------------------------------------------
module demux_1_8_behav_always
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    input logic                      clk,
    input logic                      rst_n,
    demux_1_8_behav_always_if.slave  bus
);

    demux_sel_t         sel;
    logic [NUM_OUT-1:0] onehot;
    logic [WIDTH-1:0]   y_d [NUM_OUT];
    logic [WIDTH-1:0]   y_q [NUM_OUT];

    assign sel = {bus.S3, bus.S2, bus.S1};

    demux_1_8_decode u_decode (
        .sel    (sel),
        .onehot (onehot)
    );

    // Gate the data with the one-hot enable, so at most one output can be
    // non-zero and A=0 naturally yields all-zero outputs.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            y_d[i] = '0;
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            y_d[i] = onehot[i] ? bus.A : '0;
        end
    end

    // All eight outputs are reloaded every cycle; there is no hold path, so
    // nothing from before a reset or a select change lingers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                y_q[i] <= y_d[i];
            end
        end
    end

    assign bus.Y1 = y_q[0];
    assign bus.Y2 = y_q[1];
    assign bus.Y3 = y_q[2];
    assign bus.Y4 = y_q[3];
    assign bus.Y5 = y_q[4];
    assign bus.Y6 = y_q[5];
    assign bus.Y7 = y_q[6];
    assign bus.Y8 = y_q[7];

`ifdef DEMUX_SEL_OUT_EN
    demux_sel_t sel_r;

    // The select word is captured on the same edge and with the same reset
    // value as the outputs, so sel_q always names the Y that is live now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= '0;
        end else begin
            sel_r <= sel;
        end
    end

    assign bus.sel_q = sel_r;
`endif

endmodule : demux_1_8_behav_always

// File: tb/tb_demux_1_8_behav_always.sv
// ---------------------------------------------------------------------------
// tb_demux_1_8_behav_always
// Self-checking bench for the registered 1-to-8 demultiplexer: reset
// behaviour, a constant vector table, a select sweep, mid-cycle reset,
// between-edge select changes and randomised traffic against a reference
// model. When DEMUX_SEL_OUT_EN is defined the registered select is checked.
// ---------------------------------------------------------------------------
module tb_demux_1_8_behav_always;

    localparam int TB_W = 1;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    demux_1_8_behav_always_if #(.WIDTH(TB_W)) bus ();

    demux_1_8_behav_always #(.WIDTH(TB_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TB_W-1:0]   a;
        logic [2:0]        sel;
        logic [8*TB_W-1:0] exp_y;
    } vec_t;

    vec_t vecs [12];

    // Reference: output number sel+1 carries A, every other output is zero.
    function automatic logic [8*TB_W-1:0] model_y(input logic [TB_W-1:0] a, input int sel);
        logic [8*TB_W-1:0] r;
        r = '0;
        for (int n = 1; n <= 8; n++) begin
            if (n == sel + 1) r[(n-1)*TB_W +: TB_W] = a;
        end
        return r;
    endfunction

    function automatic logic [8*TB_W-1:0] get_y();
        return {bus.Y8, bus.Y7, bus.Y6, bus.Y5, bus.Y4, bus.Y3, bus.Y2, bus.Y1};
    endfunction

    task automatic check_output(input string name, input logic [8*TB_W-1:0] act,
                                input logic [8*TB_W-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got Y8..Y1=%b expected %b", name, act, exp_v);
        end
    endtask

    task automatic check_sel_q(input string name, input logic [2:0] exp_s);
`ifdef DEMUX_SEL_OUT_EN
        total++;
        if (bus.sel_q !== exp_s) begin
            bad++;
            $display("[TB] FAIL %s: got sel_q=%b expected %b", name, bus.sel_q, exp_s);
        end
`else
        if (exp_s > 3'd7) $display("[TB] unreachable %s", name);
`endif
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the
    // following rising edge.
    task automatic apply_stimulus(input logic [TB_W-1:0] a, input logic [2:0] sel);
        @(negedge clk);
        bus.A  = a;
        {bus.S3, bus.S2, bus.S1} = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TB_W-1:0] ra;
        logic [2:0]      rs;

        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b1, 3'd0, 8'b0000_0001};
        vecs[1]  = '{1'b1, 3'd1, 8'b0000_0010};
        vecs[2]  = '{1'b1, 3'd2, 8'b0000_0100};
        vecs[3]  = '{1'b1, 3'd3, 8'b0000_1000};
        vecs[4]  = '{1'b1, 3'd4, 8'b0001_0000};
        vecs[5]  = '{1'b1, 3'd5, 8'b0010_0000};
        vecs[6]  = '{1'b1, 3'd6, 8'b0100_0000};
        vecs[7]  = '{1'b1, 3'd7, 8'b1000_0000};
        vecs[8]  = '{1'b0, 3'd7, 8'b0000_0000};
        vecs[9]  = '{1'b0, 3'd0, 8'b0000_0000};
        vecs[10] = '{1'b1, 3'd3, 8'b0000_1000};
        vecs[11] = '{1'b0, 3'd3, 8'b0000_0000};

        // Reset held with live inputs and a running clock
        rst_n = 1'b0;
        bus.A = 1'b1;
        {bus.S3, bus.S2, bus.S1} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_hold", get_y(), 8'h00);
        check_sel_q("reset_hold_sel", 3'b000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("reset_release_no_edge", get_y(), 8'h00);
        @(posedge clk);
        #1;
        check_output("reset_release_first_edge", get_y(), 8'h01);

        // Constant vector table
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].a, vecs[i].sel);
            check_output($sformatf("vec%0d", i), get_y(), vecs[i].exp_y);
            check_sel_q($sformatf("vec%0d_sel", i), vecs[i].sel);
        end

        // Sweep with each select held for 5 cycles
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 5; c++) begin
                apply_stimulus(1'b1, 3'(s));
                check_output($sformatf("sweep_s%0d_c%0d", s, c), get_y(), model_y(1'b1, s));
            end
        end

        // A=0 on every select
        for (int s = 0; s < 8; s++) begin
            apply_stimulus(1'b0, 3'(s));
            check_output($sformatf("a0_s%0d", s), get_y(), 8'h00);
        end

        // Mid-cycle asynchronous reset with Y6 live
        apply_stimulus(1'b1, 3'b101);
        check_output("pre_async_reset", get_y(), 8'b0010_0000);
        check_sel_q("pre_async_reset_sel", 3'b101);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_no_edge", get_y(), 8'h00);
        check_sel_q("async_reset_sel", 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("after_async_reset", get_y(), 8'b0010_0000);

        // Select change between edges has no effect until the next edge
        apply_stimulus(1'b1, 3'b010);
        check_output("between_edges_before", get_y(), 8'b0000_0100);
        #1;
        {bus.S3, bus.S2, bus.S1} = 3'b110;
        #2;
        check_output("between_edges_hold", get_y(), 8'b0000_0100);
        @(posedge clk);
        #1;
        check_output("between_edges_after", get_y(), 8'b0100_0000);
        check_sel_q("between_edges_sel", 3'b110);

        // Randomised traffic against the reference model
        for (int k = 0; k < 200; k++) begin
            ra = TB_W'($urandom_range(0, (1 << TB_W) - 1));
            rs = 3'($urandom_range(0, 7));
            apply_stimulus(ra, rs);
            check_output($sformatf("rand%0d", k), get_y(), model_y(ra, int'(rs)));
            check_sel_q($sformatf("rand%0d_sel", k), rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_1_8_behav_always
